inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Purpose:
//   Instruction fetch front end between the IF stage of the datapath and an
//   instruction memory with a request/ack handshake. A one-entry holding
//   buffer returns a repeated fetch of the same word with no wait. On a miss,
//   a three-state FSM (IDLE / REQ / ERR) issues one word-aligned bus request
//   and waits for the memory strobe. The returned word can reach the IF stage
//   in the same cycle as the ack (ack bypass). If the memory never answers,
//   the block parks in ERR with a sticky error flag until reset.
//
// Parameters:
//   TIMEOUT_CYCLES  number of REQ cycles without ack before ERR (1..255)
//
// Ports:
//   i_clk          main clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset, highest priority
//   i_inst_ren     instruction read enable from the IF stage
//   i_inst_addr    byte address of the instruction wanted
//   i_inst_inval   one-cycle pulse that invalidates the holding buffer
//   o_inst_data    instruction returned to the IF stage (combinational)
//   o_inst_stall   high while the requested word is unavailable
//   o_fetch_err    sticky bus-timeout flag
//   o_bus_req      request strobe to instruction memory
//   o_bus_addr     word-aligned request address
//   i_bus_ack      one-cycle response strobe from memory
//   i_bus_rdata    response data, meaningful only with i_bus_ack
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_ren,
  input  logic [31:0] i_inst_addr,
  input  logic        i_inst_inval,
  output logic [31:0] o_inst_data,
  output logic        o_inst_stall,
  output logic        o_fetch_err,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  // Counter compare value; the counter is 8 bits wide.
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  // Clears the byte-offset bits so that every stored or compared address is
  // a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = addr & 32'hFFFF_FFFC;
  endfunction

  // Architectural state.
  state_t      r_state;
  logic        r_buf_valid;
  logic [31:0] r_buf_addr;
  logic [31:0] r_buf_data;
  logic [31:0] r_req_addr;
  logic [7:0]  r_cnt;
  logic        r_fetch_err;

  // Next-state values produced by the combinational process.
  state_t      w_state_nxt;
  logic        w_buf_valid_nxt;
  logic [31:0] w_buf_addr_nxt;
  logic [31:0] w_buf_data_nxt;
  logic [31:0] w_req_addr_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_fetch_err_nxt;

  // Decoded conditions.
  logic [31:0] w_inst_word;
  logic [7:0]  w_cnt_inc;
  logic        w_hit;
  logic        w_bypass;

  assign w_inst_word = word_align(i_inst_addr);
  assign w_cnt_inc   = r_cnt + 8'd1;

  // Buffer hit and ack bypass. Both are suppressed while reset is asserted so
  // that the IF stage sees a stall and a zero word during reset. The buffer
  // address is always stored word-aligned, so a full compare against the
  // aligned request address ignores the byte offset.
  always_comb begin
    w_hit    = 1'b0;
    w_bypass = 1'b0;
    if (i_rst) begin
      w_hit    = 1'b0;
      w_bypass = 1'b0;
    end else begin
      w_hit    = r_buf_valid & (r_buf_addr == w_inst_word) & ~i_inst_inval;
      w_bypass = (r_state == ST_REQ) & i_bus_ack & i_inst_ren &
                 (r_req_addr == w_inst_word);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 32'h0000_0000;
      r_buf_data  <= 32'h0000_0000;
      r_req_addr  <= 32'h0000_0000;
      r_cnt       <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end

  // FSM next state, buffer fill and timeout counting.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_data_nxt  = r_buf_data;
    w_req_addr_nxt  = r_req_addr;
    w_cnt_nxt       = r_cnt;
    w_fetch_err_nxt = r_fetch_err;

    case (r_state)
      ST_IDLE: begin
        // Acks arriving here are stray and are dropped.
        if (i_inst_ren & ~w_hit) begin
          w_state_nxt    = ST_REQ;
          w_req_addr_nxt = w_inst_word;
          w_cnt_nxt      = 8'd0;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_REQ: begin
        // The fill completes even when the IF stage has moved on (redirect
        // or read enable dropped); the next IDLE cycle simply misses again.
        if (i_bus_ack) begin
          w_state_nxt = ST_IDLE;
          if (~i_inst_inval) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_addr_nxt  = r_req_addr;
            w_buf_data_nxt  = i_bus_rdata;
          end else begin
            // Invalidate wins over the fill: nothing is loaded.
            w_buf_valid_nxt = 1'b0;
          end
        end else if (w_cnt_inc == TIMEOUT_LIM) begin
          w_state_nxt     = ST_ERR;
          w_cnt_nxt       = w_cnt_inc;
          w_fetch_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt       = w_cnt_inc;
        end
      end

      ST_ERR: begin
        // Parked until reset; acks are ignored.
        w_state_nxt = ST_ERR;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // An invalidate pulse always empties the buffer on the next edge.
    if (i_inst_inval) begin
      w_buf_valid_nxt = 1'b0;
    end else begin
      w_buf_valid_nxt = w_buf_valid_nxt;
    end
  end

  // IF-stage facing outputs: data selection and stall.
  always_comb begin
    o_inst_data  = r_buf_data;
    o_inst_stall = 1'b0;
    if (i_rst) begin
      o_inst_data  = 32'h0000_0000;
      o_inst_stall = i_inst_ren;
    end else if (r_state == ST_ERR) begin
      // No word can ever arrive, so every read stalls.
      o_inst_data  = r_buf_data;
      o_inst_stall = i_inst_ren;
    end else if (w_bypass) begin
      o_inst_data  = i_bus_rdata;
      o_inst_stall = 1'b0;
    end else if (w_hit) begin
      o_inst_data  = r_buf_data;
      o_inst_stall = 1'b0;
    end else begin
      o_inst_data  = r_buf_data;
      o_inst_stall = i_inst_ren;
    end
  end

  // Memory facing outputs; request and address come straight from state.
  always_comb begin
    o_bus_req  = 1'b0;
    o_bus_addr = 32'h0000_0000;
    if (i_rst) begin
      o_bus_req  = 1'b0;
      o_bus_addr = 32'h0000_0000;
    end else begin
      o_bus_req  = (r_state == ST_REQ);
      o_bus_addr = r_req_addr;
    end
  end

  assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Cycle-by-cycle vectors: each record holds the inputs for one clock cycle and
// the outputs expected in that cycle. The driver applies a record just after
// the rising edge and pushes it to a scoreboard queue; the monitor pops it on
// the falling edge and compares. The DUT runs with TIMEOUT_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic        inst_inval;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        fetch_err;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  inst_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inst_ren   (inst_ren),
    .i_inst_addr  (inst_addr),
    .i_inst_inval (inst_inval),
    .o_inst_data  (inst_data),
    .o_inst_stall (inst_stall),
    .o_fetch_err  (fetch_err),
    .o_bus_req    (bus_req),
    .o_bus_addr   (bus_addr),
    .i_bus_ack    (bus_ack),
    .i_bus_rdata  (bus_rdata)
  );

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        inval;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_err;
    logic        e_req;
    logic [31:0] e_baddr;
    logic        chk_baddr;
    int          id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  vec_t exp_v;
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  function automatic vec_t mk(input logic r, input logic ren, input logic [31:0] a,
                              input logic inv, input logic ack, input logic [31:0] rd,
                              input logic [31:0] ed, input logic es, input logic ee,
                              input logic er, input logic [31:0] eba, input logic cba);
    vec_t v;
    v.rst = r;  v.ren = ren; v.addr = a; v.inval = inv; v.ack = ack; v.rdata = rd;
    v.e_data = ed; v.e_stall = es; v.e_err = ee; v.e_req = er;
    v.e_baddr = eba; v.chk_baddr = cba; v.id = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst        = v.rst;
    inst_ren   = v.ren;
    inst_addr  = v.addr;
    inst_inval = v.inval;
    bus_ack    = v.ack;
    bus_rdata  = v.rdata;
    v.id       = vec_id;
    vec_id     = vec_id + 1;
    sb_q.push_back(v);
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s vec%0d: got 0x%08h, expected 0x%08h", nm, id, act, req);
    end
  endtask

  // Scoreboard monitor: compare the outputs of the cycle in progress.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      chk("inst_data",  exp_v.id, inst_data,          exp_v.e_data);
      chk("inst_stall", exp_v.id, {31'd0, inst_stall}, {31'd0, exp_v.e_stall});
      chk("fetch_err",  exp_v.id, {31'd0, fetch_err},  {31'd0, exp_v.e_err});
      chk("bus_req",    exp_v.id, {31'd0, bus_req},    {31'd0, exp_v.e_req});
      if (exp_v.chk_baddr) begin
        chk("bus_addr", exp_v.id, bus_addr, exp_v.e_baddr);
      end
    end
  end

  // Hard stop in case the run never reaches its end.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; inst_ren = 1'b0; inst_addr = 32'h0; inst_inval = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;

    //            rst   ren   addr          inv   ack   rdata          e_data         stl   err   req   baddr         chk
    // Reset state
    tbl.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1));
    // Cold miss of 0x0: three stall cycles, bypass on the ack, then a hit
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h2010_0001, 32'h2010_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h2010_0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    // Fill 0x4 with a same-cycle ack, hit on 0x4 and 0x6, then miss on 0x8
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,         32'h2010_0001, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'hA0A0_0004, 32'hA0A0_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,         32'hA0A0_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0,         32'hA0A0_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,         32'hA0A0_0004, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,         32'hA0A0_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0888, 32'h0000_0888, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1));
    // Redirect: 0x10 in flight, IF moves to 0x40; stale fill, then 0x40 fetched
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'h0000_0888, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         32'h0000_0888, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h1010_1010, 32'h0000_0888, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         32'h1010_1010, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h4040_4040, 32'h4040_4040, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         32'h4040_4040, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    // Read enable drops mid-request: no stall, no bypass, fill still lands
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0,         32'h4040_4040, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 32'h0,         32'h4040_4040, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b1, 32'h3333_3333, 32'h4040_4040, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0,         32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    // Stray ack in IDLE leaves the buffer alone
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0,         32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));
    // Invalidate masks the hit in its own cycle and forces a re-fetch
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b1, 1'b0, 32'h0,         32'h3333_3333, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b1, 32'h3434_3434, 32'h3434_3434, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 1'b1));
    // Invalidate on the ack of 0x20: bypass works, no load, re-request 0x20
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h3434_3434, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h2020_2020, 32'h2020_2020, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h3434_3434, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h3434_3434, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h2121_2121, 32'h2121_2121, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 32'h0,         32'h2121_2121, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
    end

    // Reset in the middle of a request for 0x50, then a late ack
    drive(mk(1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'h0,         32'h2121_2121, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    drive(mk(1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'h0,         32'h2121_2121, 1'b1, 1'b0, 1'b1, 32'h0000_0050, 1'b1));
    drive(mk(1'b1, 1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1));
    drive(mk(1'b0, 1'b0, 32'h0000_0050, 1'b0, 1'b1, 32'h5555_5555, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1));
    // Address 0 must miss: the cleared buffer is not valid
    drive(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1));
    drive(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_00AA, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1));

    // Timeout after four REQ cycles with no ack, then ERR behaviour and reset
    drive(mk(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0,         32'h0000_00AA, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0));
    for (int k = 0; k < 4; k++) begin
      drive(mk(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0,       32'h0000_00AA, 1'b1, 1'b0, 1'b1, 32'h0000_0060, 1'b1));
    end
    drive(mk(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0,         32'h0000_00AA, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0));
    drive(mk(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b1, 32'h6666_6666, 32'h0000_00AA, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0));
    drive(mk(1'b0, 1'b0, 32'h0000_0060, 1'b0, 1'b0, 32'h0,         32'h0000_00AA, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0));
    drive(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0000_00AA, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0));
    drive(mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1));
    drive(mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", vec_id, sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
